// File: rtl/frame_draw_scheduler.sv
// -----------------------------------------------------------------------------
// frame_draw_scheduler
//
// Purpose:
//   Sequences one frame of drawing per vertical sync. First the environment /
//   tile engine runs, then the sprite subsystem. The finished back buffer is
//   presented at the next VSYNC falling edge. A draw that runs past a VSYNC
//   edge is flagged as an overrun and still completes. A draw phase that never
//   reports done is abandoned after TIMEOUT_CYCLES and flagged.
//
// Ports:
//   CLOCK_50        in   50 MHz master clock
//   RESET_N         in   asynchronous active-low reset
//   ENABLE          in   level, permits frame scheduling
//   VSYNC_N         in   raw VGA vertical sync (active-low), CLOCK_50 domain
//   ENTITY_COUNT    in   last entity-file address to draw
//   ENV_RUN         out  environment engine run level
//   ENV_DONE        in   environment engine done status
//   SPR_RUN         out  sprite subsystem run level
//   SPR_QUEUE_DONE  in   sprite subsystem queue-done status
//   STOP_ADDRESS    out  ENTITY_COUNT latched at the start of each frame
//   BUF_SELECT      out  back buffer currently being drawn
//   SWAP            out  one-cycle buffer swap pulse
//   FRAME_COUNT     out  presented-frame counter (wraps)
//   BUSY            out  high while a draw phase is active
//   OVERRUN         out  sticky: VSYNC edge arrived while drawing
//   TIMEOUT_ERR     out  sticky: a draw phase hit the cycle limit
//   CLEAR_ERR       in   clears OVERRUN / TIMEOUT_ERR (a same-cycle set wins)
//
// All outputs come straight from flops, so no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module frame_draw_scheduler #(
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd800000
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic        ENABLE,
  input  logic        VSYNC_N,
  input  logic [2:0]  ENTITY_COUNT,
  output logic        ENV_RUN,
  input  logic        ENV_DONE,
  output logic        SPR_RUN,
  input  logic        SPR_QUEUE_DONE,
  output logic [2:0]  STOP_ADDRESS,
  output logic        BUF_SELECT,
  output logic        SWAP,
  output logic [15:0] FRAME_COUNT,
  output logic        BUSY,
  output logic        OVERRUN,
  output logic        TIMEOUT_ERR,
  input  logic        CLEAR_ERR
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_VS,
    S_ENV_DRAW,
    S_SPR_DRAW,
    S_WAIT_SWAP
  } state_e;

  state_e      state_q, state_d;
  logic        vs_q;
  logic [19:0] phase_cnt_q, phase_cnt_d;
  logic        env_run_q, spr_run_q, busy_q, swap_q;
  logic        buf_q, overrun_q, timeout_q;
  logic [15:0] frame_q;
  logic [2:0]  stop_q;

  logic vs_edge;
  logic in_draw;
  logic phase_first;
  logic phase_expired;
  logic swap_d;
  logic latch_stop;
  logic overrun_set;
  logic timeout_set;

  // VSYNC_N is already synchronous to CLOCK_50; one history flop is enough to
  // find the falling edge. History resets to 1 so a low VSYNC_N at reset
  // release is not mistaken for an edge.
  assign vs_edge = vs_q & ~VSYNC_N;

  assign in_draw       = (state_q == S_ENV_DRAW) || (state_q == S_SPR_DRAW);
  // The done inputs may still be high from the previous frame, so they are
  // only trusted from the second cycle of a phase onward.
  assign phase_first   = (phase_cnt_q == 20'd0);
  assign phase_expired = (phase_cnt_q == TIMEOUT_CYCLES - 20'd1);
  assign overrun_set   = vs_edge && in_draw;

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    swap_d      = 1'b0;
    latch_stop  = 1'b0;
    timeout_set = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ENABLE) state_d = S_WAIT_VS;
      end
      S_WAIT_VS: begin
        if (!ENABLE) begin
          state_d = S_IDLE;
        end else if (vs_edge) begin
          state_d    = S_ENV_DRAW;
          latch_stop = 1'b1;
        end
      end
      // ENABLE is deliberately ignored while drawing: a frame once started
      // always completes and is always presented.
      S_ENV_DRAW: begin
        if (!phase_first && ENV_DONE) begin
          state_d = S_SPR_DRAW;
        end else if (phase_expired) begin
          state_d     = S_WAIT_SWAP;
          timeout_set = 1'b1;
        end
      end
      S_SPR_DRAW: begin
        if (!phase_first && SPR_QUEUE_DONE) begin
          state_d = S_WAIT_SWAP;
        end else if (phase_expired) begin
          state_d     = S_WAIT_SWAP;
          timeout_set = 1'b1;
        end
      end
      S_WAIT_SWAP: begin
        if (vs_edge) begin
          swap_d = 1'b1;
          if (ENABLE) begin
            state_d    = S_ENV_DRAW;
            latch_stop = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The phase counter restarts on every entry into a draw state and idles at
  // zero elsewhere. Timeout forces an exit, so it never needs to saturate.
  always_comb begin
    phase_cnt_d = 20'd0;
    if (((state_d == S_ENV_DRAW) || (state_d == S_SPR_DRAW)) && (state_d == state_q)) begin
      phase_cnt_d = phase_cnt_q + 20'd1;
    end
  end

  // Run/busy outputs are registered from the next state, so they track the
  // state register exactly. The two run levels can never overlap because they
  // decode mutually exclusive states.
  // NOTE: all state is updated with non-blocking assignments so every flop
  // samples the values from before the clock edge, regardless of statement order.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= S_IDLE;
      vs_q        <= 1'b1;
      phase_cnt_q <= 20'd0;
      env_run_q   <= 1'b0;
      spr_run_q   <= 1'b0;
      busy_q      <= 1'b0;
      swap_q      <= 1'b0;
      buf_q       <= 1'b0;
      frame_q     <= 16'd0;
      stop_q      <= 3'd0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      vs_q        <= VSYNC_N;
      phase_cnt_q <= phase_cnt_d;
      env_run_q   <= (state_d == S_ENV_DRAW);
      spr_run_q   <= (state_d == S_SPR_DRAW);
      busy_q      <= (state_d == S_ENV_DRAW) || (state_d == S_SPR_DRAW);
      swap_q      <= swap_d;
      buf_q       <= buf_q ^ swap_d;
      frame_q     <= frame_q + {15'd0, swap_d};
      if (latch_stop) stop_q <= ENTITY_COUNT;
      // Set has priority over clear when both happen in the same cycle.
      overrun_q   <= overrun_set | (overrun_q & ~CLEAR_ERR);
      timeout_q   <= timeout_set | (timeout_q & ~CLEAR_ERR);
    end
  end

  assign ENV_RUN      = env_run_q;
  assign SPR_RUN      = spr_run_q;
  assign BUSY         = busy_q;
  assign SWAP         = swap_q;
  assign BUF_SELECT   = buf_q;
  assign FRAME_COUNT  = frame_q;
  assign STOP_ADDRESS = stop_q;
  assign OVERRUN      = overrun_q;
  assign TIMEOUT_ERR  = timeout_q;

endmodule

// File: tb/tb_frame_draw_scheduler.sv
// -----------------------------------------------------------------------------
// tb_frame_draw_scheduler
//
// Drives frames through frame_draw_scheduler and predicts, frame by frame,
// how long each draw phase lasts, whether the sticky error flags are set,
// when the swap happens, and what FRAME_COUNT / BUF_SELECT / STOP_ADDRESS
// show. Directed frames cover the corner cases first; randomized frames follow.
// -----------------------------------------------------------------------------
module tb_frame_draw_scheduler;

  localparam int T = 300;  // TIMEOUT_CYCLES used for the DUT

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        vsync_n;
  logic [2:0]  entity_count;
  logic        env_run, env_done;
  logic        spr_run, spr_done;
  logic [2:0]  stop_address;
  logic        buf_select, swap;
  logic [15:0] frame_count;
  logic        busy, overrun, timeout_err, clear_err;

  always #5 clk = ~clk;

  frame_draw_scheduler #(.TIMEOUT_CYCLES(20'(T))) dut (
    .CLOCK_50       (clk),
    .RESET_N        (rst_n),
    .ENABLE         (enable),
    .VSYNC_N        (vsync_n),
    .ENTITY_COUNT   (entity_count),
    .ENV_RUN        (env_run),
    .ENV_DONE       (env_done),
    .SPR_RUN        (spr_run),
    .SPR_QUEUE_DONE (spr_done),
    .STOP_ADDRESS   (stop_address),
    .BUF_SELECT     (buf_select),
    .SWAP           (swap),
    .FRAME_COUNT    (frame_count),
    .BUSY           (busy),
    .OVERRUN        (overrun),
    .TIMEOUT_ERR    (timeout_err),
    .CLEAR_ERR      (clear_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int       frame_m;
  logic     buf_m, ov_m, to_m;
  logic [2:0] stop_exp, ec_cur;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // A phase with done first presented at cycle d lasts max(d,1)+1 cycles
  // (done is ignored in the first cycle), capped at T cycles by the timeout.
  function automatic int exp_len(input int d);
    int dd = (d < 1) ? 1 : d;
    return (dd <= T - 1) ? dd + 1 : T;
  endfunction

  function automatic bit exp_timeout(input int d);
    int dd = (d < 1) ? 1 : d;
    return dd > T - 1;
  endfunction

  task automatic reset_model();
    frame_m  = 0;
    buf_m    = 1'b0;
    ov_m     = 1'b0;
    to_m     = 1'b0;
    stop_exp = 3'd0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_env_run"}, env_run, 0);
    check({tag, "_spr_run"}, spr_run, 0);
    check({tag, "_swap"}, swap, 0);
    check({tag, "_buf"}, buf_select, 0);
    check({tag, "_frame"}, frame_count, 0);
    check({tag, "_stop"}, stop_address, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_timeout"}, timeout_err, 0);
  endtask

  // Continuous invariants, sampled away from the active edge.
  logic swap_prev = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      check("run_overlap", env_run & spr_run, 0);
      check("busy_decode", busy, env_run | spr_run);
      check("swap_width", swap_prev & swap, 0);
      swap_prev <= swap;
    end else begin
      swap_prev <= 1'b0;
    end
  end

  // Runs one draw phase starting at the negedge of its first cycle. Done is
  // presented from cycle index d on; a one-cycle VSYNC_N low is injected at
  // ov_at and a CLEAR_ERR pulse at clr_at (negative = never).
  task automatic run_phase(input bit is_spr, input int d, input int ov_at,
                           input int clr_at, output int len);
    int   i = 0;
    logic done;
    while ((is_spr ? spr_run : env_run) && i < T + 10) begin
      done = (i >= d);
      if (is_spr) spr_done = done; else env_done = done;
      vsync_n   = (i == ov_at) ? 1'b0 : 1'b1;
      clear_err = (i == clr_at);
      if (i == T - 1 && !(i >= 1 && done)) to_m = 1'b1;
      else if (i == clr_at)                to_m = 1'b0;
      if (i == ov_at)       ov_m = 1'b1;
      else if (i == clr_at) ov_m = 1'b0;
      i++;
      @(negedge clk);
    end
    env_done  = 1'b0;
    spr_done  = 1'b0;
    vsync_n   = 1'b1;
    clear_err = 1'b0;
    len = i;
  endtask

  // Starts at the negedge of the first ENV_DRAW cycle of a frame and ends at
  // the negedge of the first ENV_DRAW cycle of the next frame.
  task automatic run_frame(input int d_env, input int d_spr, input int ov_env,
                           input int ov_spr, input int clr_env, input bit en_draw,
                           input bit en_next, input bit clr_wait, input int swap_wait);
    int len;
    check("frame_start_env_run", env_run, 1);
    check("stop_latched", stop_address, stop_exp);
    check("frame_count_pre", frame_count, frame_m);
    check("buf_pre", buf_select, buf_m);
    enable       = en_draw;
    ec_cur       = 3'($urandom);
    entity_count = ec_cur;

    run_phase(1'b0, d_env, ov_env, clr_env, len);
    check("env_len", len, exp_len(d_env));
    check("env_spr_handoff", spr_run, !exp_timeout(d_env));
    check("timeout_after_env", timeout_err, to_m);
    if (spr_run) begin
      run_phase(1'b1, d_spr, ov_spr, -1, len);
      check("spr_len", len, exp_len(d_spr));
    end
    check("wait_swap_idle", {env_run, spr_run, busy}, 0);
    check("overrun", overrun, ov_m);
    check("timeout", timeout_err, to_m);
    check("stop_held", stop_address, stop_exp);

    enable = en_next;
    if (clr_wait) begin
      clear_err = 1'b1;
      ov_m      = 1'b0;
      to_m      = 1'b0;
    end
    repeat (swap_wait + 1) begin
      @(negedge clk);
      clear_err = 1'b0;
      check("no_early_swap", swap, 0);
    end
    check("flags_wait", {overrun, timeout_err}, {ov_m, to_m});

    vsync_n = 1'b0;
    @(negedge clk);
    vsync_n = 1'b1;
    frame_m = (frame_m + 1) & 16'hFFFF;
    buf_m   = ~buf_m;
    check("swap_pulse", swap, 1);
    check("frame_count", frame_count, frame_m);
    check("buf_select", buf_select, buf_m);
    check("next_env_run", env_run, en_next);
    if (en_next) begin
      stop_exp = ec_cur;
    end else begin
      @(negedge clk);
      check("idle_after_swap", {env_run, spr_run, busy, swap}, 0);
      vsync_n = 1'b0;
      @(negedge clk);
      vsync_n = 1'b1;
      @(negedge clk);
      check("idle_ignores_vs", {env_run, spr_run, busy, swap}, 0);
      ec_cur       = 3'($urandom);
      entity_count = ec_cur;
      enable       = 1'b1;
      @(negedge clk);
      vsync_n = 1'b0;
      @(negedge clk);
      vsync_n  = 1'b1;
      stop_exp = ec_cur;
    end
  endtask

  // From IDLE with VSYNC_N high: enable, wait for WAIT_VS, start a frame.
  task automatic start_from_idle();
    enable       = 1'b1;
    entity_count = ec_cur;
    @(negedge clk);
    check("wait_vs_not_busy", {env_run, spr_run, busy}, 0);
    vsync_n = 1'b0;
    @(negedge clk);
    vsync_n  = 1'b1;
    stop_exp = ec_cur;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int de, ds, oe, os, ce, sw;
  bit ed, en, cw;

  initial begin
    rst_n = 1'b0; enable = 1'b0; vsync_n = 1'b1; entity_count = 3'd0;
    env_done = 1'b0; spr_done = 1'b0; clear_err = 1'b0;
    ec_cur = 3'd3;
    reset_model();
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_enable", {env_run, spr_run, busy}, 0);

    // VSYNC edge in IDLE, and ENABLE dropping in WAIT_VS, start nothing.
    vsync_n = 1'b0; @(negedge clk); vsync_n = 1'b1; @(negedge clk);
    check("idle_vs_ignored", env_run, 0);
    enable = 1'b1; @(negedge clk);
    enable = 1'b0; @(negedge clk);
    vsync_n = 1'b0; @(negedge clk); vsync_n = 1'b1; @(negedge clk);
    check("wait_vs_disable", env_run, 0);

    start_from_idle();
    // d_env d_spr ov_env ov_spr clr_env en_draw en_next clr_wait swap_wait
    run_frame(100, 200, -1, -1, -1,    1, 1, 0, 3);  // normal frame
    run_frame(0,   0,   -1, -1, -1,    1, 1, 0, 0);  // stale done in both phases
    run_frame(10,  20,  -1,  5, -1,    1, 1, 0, 2);  // overrun during sprites
    run_frame(5,   5,   -1, -1,  1,    1, 1, 0, 1);  // clear overrun
    run_frame(T+100, 0,  2, -1, -1,    1, 1, 1, 2);  // env timeout, clear in wait
    run_frame(T+5, 0,   -1, -1, T-1,   1, 1, 0, 0);  // set beats same-cycle clear
    run_frame(T-1, T,   -1, -1, 0,     1, 1, 0, 1);  // done on last cycle; spr timeout
    run_frame(8,   12,  -1, -1, -1,    0, 0, 1, 3);  // disable mid-draw, then idle

    for (int k = 0; k < 30; k++) begin
      de = ($urandom_range(0, 7) == 0) ? $urandom_range(T-2, T+2) : $urandom_range(0, 30);
      ds = ($urandom_range(0, 7) == 0) ? $urandom_range(T-2, T+2) : $urandom_range(0, 30);
      oe = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : -1;
      os = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : -1;
      ce = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : -1;
      ed = 1'($urandom_range(0, 1));
      en = ($urandom_range(0, 3) != 0);
      cw = ($urandom_range(0, 3) == 0);
      sw = $urandom_range(0, 4);
      run_frame(de, ds, oe, os, ce, ed, en, cw, sw);
    end

    // Reset in the middle of an environment phase.
    repeat (3) @(negedge clk);
    check("pre_reset_env_run", env_run, 1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    reset_model();
    @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    check("post_reset_idle", {env_run, spr_run, busy, swap}, 0);
    ec_cur = 3'd6;
    start_from_idle();
    run_frame(15, 25, -1, -1, -1, 1, 1, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
